// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//
// Stream FIFO built around a simple dual-port, single-clock SRAM macro that
// has a one-cycle registered read. The controller drives both SRAM ports and
// puts a valid/ready handshake on each end. A two-entry output stage (head
// plus skid) is refilled by prefetching SRAM reads, so a word can be popped
// on every cycle while pushes continue at the same rate.
//
// Parameters
//   DATA_SIZE  word width in bits
//   ADDR_SIZE  SRAM address width, SRAM depth = 2**ADDR_SIZE
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  producer side
//   out_valid/out_ready/out_data consumer side, out_data is the FIFO head
//   count                      words held (SRAM + in-flight read + stage)
//   write_enable/_address/_data SRAM write port
//   read_enable/_address       SRAM read port
//   read_data                  SRAM read data, one cycle after read_enable
//
// Optional feature, enabled by defining DYNFIFO_ALMOST_FLAGS_EN:
//   almost_full_level, almost_empty_level  runtime thresholds
//   almost_full  = registered (count >= almost_full_level)
//   almost_empty = registered (count <= almost_empty_level)
// -----------------------------------------------------------------------------
module sram_fifo_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [ADDR_SIZE+1:0] count,
  output logic                 write_enable,
  output logic [ADDR_SIZE-1:0] write_address,
  output logic [DATA_SIZE-1:0] write_data,
  output logic                 read_enable,
  output logic [ADDR_SIZE-1:0] read_address,
  input  logic [DATA_SIZE-1:0] read_data
`ifdef DYNFIFO_ALMOST_FLAGS_EN
  ,
  input  logic [ADDR_SIZE+1:0] almost_full_level,
  input  logic [ADDR_SIZE+1:0] almost_empty_level,
  output logic                 almost_full,
  output logic                 almost_empty
`endif
);

  localparam int MW = ADDR_SIZE + 1;  // mem_cnt width, holds 0..DEPTH
  localparam int CW = ADDR_SIZE + 2;  // count width, holds 0..DEPTH+2
  localparam logic [MW-1:0] MEM_FULL = {1'b1, {ADDR_SIZE{1'b0}}};

  // Reset: asserted asynchronously, released synchronously after two edges.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

  // State
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [MW-1:0]        mem_cnt_q, mem_cnt_d;
  logic                 rd_inflight_q, rd_inflight_d;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic                 head_vld_q, head_vld_d;
  logic [DATA_SIZE-1:0] skid_q, skid_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [CW-1:0]        count_q, count_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] pending;

  always_comb begin
    // Not ready until the internal reset has been released, so no handshake
    // can complete while the state registers are still held.
    in_ready = rst_sync_n && (mem_cnt_q < MEM_FULL);
    push     = in_valid && in_ready;
    pop      = head_vld_q && out_ready;

    // Words already committed to the output stage, including the one whose
    // read_data arrives this cycle. A slot freed by this cycle's pop may be
    // reused by a read issued in the same cycle.
    pending = 2'(head_vld_q) + 2'(skid_vld_q) + 2'(rd_inflight_q);
    issue   = (mem_cnt_q != '0) && (pending < (pop ? 2'd3 : 2'd2));

    wr_ptr_d      = wr_ptr_q + ADDR_SIZE'(push);
    rd_ptr_d      = rd_ptr_q + ADDR_SIZE'(issue);
    mem_cnt_d     = mem_cnt_q + MW'(push) - MW'(issue);
    rd_inflight_d = issue;

    head_d     = head_q;
    head_vld_d = head_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;

    if (pop) begin
      head_d     = skid_q;
      head_vld_d = skid_vld_q;
      skid_vld_d = 1'b0;
    end

    // Returning word lands in the head if it is (now) free, else in skid.
    if (rd_inflight_q) begin
      if (!head_vld_d) begin
        head_d     = read_data;
        head_vld_d = 1'b1;
      end else begin
        skid_d     = read_data;
        skid_vld_d = 1'b1;
      end
    end

    count_d = CW'(mem_cnt_d) + CW'(rd_inflight_d) + CW'(head_vld_d) + CW'(skid_vld_d);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      head_q        <= '0;
      head_vld_q    <= 1'b0;
      skid_q        <= '0;
      skid_vld_q    <= 1'b0;
      count_q       <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      head_q        <= head_d;
      head_vld_q    <= head_vld_d;
      skid_q        <= skid_d;
      skid_vld_q    <= skid_vld_d;
      count_q       <= count_d;
    end
  end

  assign write_enable  = push;
  assign write_address = wr_ptr_q;
  assign write_data    = in_data;
  assign read_enable   = issue;
  assign read_address  = rd_ptr_q;
  assign out_valid     = head_vld_q;
  assign out_data      = head_q;
  assign count         = count_q;

`ifdef DYNFIFO_ALMOST_FLAGS_EN
  logic almost_full_q;
  logic almost_empty_q;

  // Flags follow the registered count, so they trail it by one edge.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_q >= almost_full_level);
      almost_empty_q <= (count_q <= almost_empty_level);
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule
